// File: rtl/fp_sqrt_issue_pkg.sv
// Shared FPU definitions: rounding modes, fflags bit positions and rm resolution helpers.
package fp_sqrt_issue_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

  function automatic logic rm_legal(input logic [2:0] rm);
    return rm inside {RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM};
  endfunction

  // sqrt can never divide by zero, overflow or underflow
  function automatic logic [4:0] make_fflags(input logic nv, input logic nx);
    logic [4:0] f;
    f        = '0;
    f[FF_NV] = nv;
    f[FF_DZ] = 1'b0;
    f[FF_OF] = 1'b0;
    f[FF_UF] = 1'b0;
    f[FF_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fp_sqrt_issue.sv
// Issue/sequencing stage in front of the multi-cycle FSQRT unit.
// state | meaning
// IDLE  | waiting for a request while the sqrt unit is quiet
// START | one-cycle sq_start pulse, latency counter cleared
// WAIT  | sqrt unit running, counting cycles until sq_done
// RESP  | response held on rsp_* until writeback takes it
// DRAIN | flushed op still running in the unit; discard its result
module fp_sqrt_issue
  import fp_sqrt_issue_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [FLEN-1:0]  req_operand,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             sq_start,
  output logic [FLEN-1:0]  sq_operand,
  output logic [2:0]       sq_rm,
  input  logic             sq_busy,
  input  logic             sq_done,
  input  logic [FLEN-1:0]  sq_result,
  input  logic             sq_flag_nv,
  input  logic             sq_flag_nx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [FLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       rsp_fflags,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] rsp_cycles
);

  state_t             state;
  logic [FLEN-1:0]    operand_q;
  logic [2:0]         rm_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [2:0]         rm_res;

  assign rm_res     = resolve_rm(req_rm, frm);
  assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign req_ready  = (state == S_IDLE) && !sq_busy && !sq_done;
  assign sq_operand = operand_q;
  assign sq_rm      = rm_q;
  assign rsp_tag    = tag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      operand_q   <= '0;
      rm_q        <= '0;
      tag_q       <= '0;
      cnt         <= '0;
      sq_start    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_fflags  <= '0;
      rsp_illegal <= 1'b0;
      rsp_cycles  <= '0;
    end else begin
      sq_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready && !flush) begin
            operand_q <= req_operand;
            tag_q     <= req_tag;
            rm_q      <= rm_res;
            if (rm_legal(rm_res)) begin
              sq_start    <= 1'b1;
              rsp_illegal <= 1'b0;
              state       <= S_START;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b1;
              rsp_result  <= '0;
              rsp_fflags  <= '0;
              rsp_cycles  <= '0;
              state       <= S_RESP;
            end
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (sq_done) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              // count includes the done cycle itself
              rsp_result <= sq_result;
              rsp_fflags <= make_fflags(sq_flag_nv, sq_flag_nx);
              rsp_cycles <= cnt_inc;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_RESP: begin
          if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (sq_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_issue.sv
// Directed bench for fp_sqrt_issue using a stub sqrt unit with programmable latency.
module tb_fp_sqrt_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_operand;
  logic [2:0]  req_rm, frm;
  logic [4:0]  req_tag;
  logic        flush;
  logic        sq_start;
  logic [31:0] sq_operand;
  logic [2:0]  sq_rm;
  logic        sq_done;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic [4:0]  rsp_fflags;
  logic        rsp_illegal;
  logic [6:0]  rsp_cycles;

  logic        stub_busy, stub_done, tb_done;
  int          stub_left, stub_lat;
  logic [31:0] stub_res;
  logic        stub_nv, stub_nx;

  int          cyc, n_start;
  logic [31:0] op_ref;
  logic [2:0]  rm_ref;
  logic        stab_bad;

  int n_applied = 0;
  int n_err     = 0;

  always #5 clk = ~clk;

  assign sq_done = stub_done | tb_done;

  fp_sqrt_issue #(.FLEN(32), .TAG_W(5), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .req_rm(req_rm), .req_tag(req_tag), .frm(frm), .flush(flush),
    .sq_start(sq_start), .sq_operand(sq_operand), .sq_rm(sq_rm),
    .sq_busy(stub_busy), .sq_done(sq_done), .sq_result(stub_res),
    .sq_flag_nv(stub_nv), .sq_flag_nx(stub_nx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags), .rsp_illegal(rsp_illegal),
    .rsp_cycles(rsp_cycles)
  );

  // stub: done pulse arrives stub_lat cycles after the sq_start cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_left <= 0;
    end else begin
      stub_done <= 1'b0;
      if (sq_start) begin
        stub_busy <= 1'b1;
        stub_left <= stub_lat - 1;
      end else if (stub_busy) begin
        if (stub_left <= 1) begin
          stub_done <= 1'b1;
          stub_busy <= 1'b0;
        end else begin
          stub_left <= stub_left - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sq_start === 1'b1) begin
      n_start <= n_start + 1;
      op_ref  <= sq_operand;
      rm_ref  <= sq_rm;
    end
    if ((stub_busy || stub_done) && (sq_operand !== op_ref || sq_rm !== rm_ref))
      stab_bad <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    int          lat;
    logic [31:0] res;
    logic        nv;
    logic        nx;
    logic        illegal;
    logic [31:0] exp_res;
    logic [4:0]  exp_ff;
    logic [6:0]  exp_cyc;
    logic [2:0]  exp_rm;
  } vec_t;

  vec_t vecs[7];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // issue one request, wait for its response, optionally stall writeback for hold cycles
  task automatic run_vec(input vec_t v, input int idx, input int hold);
    int  t0, s0;
    bit  got;
    logic [4:0] tag;
    tag         = 5'(idx + 3);
    stub_lat    = v.lat;
    stub_res    = v.res;
    stub_nv     = v.nv;
    stub_nx     = v.nx;
    req_valid   = 1'b1;
    req_operand = v.op;
    req_rm      = v.rm;
    req_tag     = tag;
    frm         = v.frm;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (req_ready) begin got = 1; break; end
      step();
    end
    chk("accept_wait", 64'(got), 64'(1));
    s0 = n_start;
    step();
    req_valid = 1'b0;
    t0 = cyc;
    chk("sq_start_c1", 64'(sq_start), 64'(!v.illegal));
    chk("rsp_valid_c1", 64'(rsp_valid), 64'(v.illegal));
    if (!v.illegal) chk("sq_rm", 64'(sq_rm), 64'(v.exp_rm));
    got = 0;
    for (int k = 0; k < 400; k++) begin
      if (rsp_valid) begin got = 1; break; end
      step();
    end
    chk("rsp_wait", 64'(got), 64'(1));
    chk("latency", 64'(cyc - t0), v.illegal ? 64'(0) : 64'(v.lat + 1));
    chk("rsp_result", 64'(rsp_result), 64'(v.exp_res));
    chk("rsp_tag", 64'(rsp_tag), 64'(tag));
    chk("rsp_fflags", 64'(rsp_fflags), 64'(v.exp_ff));
    chk("rsp_illegal", 64'(rsp_illegal), 64'(v.illegal));
    chk("rsp_cycles", 64'(rsp_cycles), 64'(v.exp_cyc));
    for (int k = 0; k < hold; k++) begin
      req_valid   = 1'b1;
      req_operand = 32'h3F800000;
      req_rm      = 3'b000;
      step();
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_result", 64'(rsp_result), 64'(v.exp_res));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_released", 64'(rsp_valid), 64'(0));
    chk("start_count", 64'(n_start - s0), v.illegal ? 64'(0) : 64'(1));
  endtask

  // start a normal op, flush fdelay cycles after the start cycle, then expect a silent drain
  task automatic flush_drain(input int fdelay);
    int  s0;
    bit  bad_valid, bad_ready, got;
    stub_lat    = 20;
    stub_res    = 32'h12345678;
    req_valid   = 1'b1;
    req_operand = 32'h41100000;
    req_rm      = 3'b000;
    req_tag     = 5'd9;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (req_ready) begin got = 1; break; end
      step();
    end
    chk("fl_accept_wait", 64'(got), 64'(1));
    s0 = n_start;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < fdelay; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bad_valid = 0;
    bad_ready = 0;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid) bad_valid = 1;
      if (sq_done) begin got = 1; break; end
      if (req_ready) bad_ready = 1;
      step();
    end
    chk("fl_done_wait", 64'(got), 64'(1));
    step();
    chk("fl_no_rsp", 64'(bad_valid | rsp_valid), 64'(0));
    chk("fl_ready_low", 64'(bad_ready), 64'(0));
    chk("fl_ready_after", 64'(req_ready), 64'(1));
    chk("fl_start_count", 64'(n_start - s0), 64'(1));
  endtask

  initial begin
    bit got;
    int s0;
    vecs[0] = '{32'h40800000, 3'b000, 3'b000, 20,  32'h40000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'b00000, 7'd20,  3'b000};
    vecs[1] = '{32'hBF800000, 3'b000, 3'b000, 10,  32'h7FC00000, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 5'b10000, 7'd10,  3'b000};
    vecs[2] = '{32'h40000000, 3'b111, 3'b011, 15,  32'h3FB504F3, 1'b0, 1'b1, 1'b0, 32'h3FB504F3, 5'b00001, 7'd15,  3'b011};
    vecs[3] = '{32'h40000000, 3'b111, 3'b101, 15,  32'h3FB504F3, 1'b0, 1'b1, 1'b1, 32'h00000000, 5'b00000, 7'd0,   3'b000};
    vecs[4] = '{32'h40400000, 3'b110, 3'b000, 15,  32'h3FDDB3D7, 1'b1, 1'b1, 1'b1, 32'h00000000, 5'b00000, 7'd0,   3'b000};
    vecs[5] = '{32'h41100000, 3'b100, 3'b000, 2,   32'h40400000, 1'b1, 1'b1, 1'b0, 32'h40400000, 5'b10001, 7'd2,   3'b100};
    vecs[6] = '{32'h41800000, 3'b111, 3'b010, 130, 32'h40800000, 1'b0, 1'b0, 1'b0, 32'h40800000, 5'b00000, 7'd127, 3'b010};

    cyc = 0; n_start = 0; op_ref = '0; rm_ref = '0; stab_bad = 1'b0;
    reset_n = 1'b0; req_valid = 1'b0; req_operand = '0; req_rm = '0; req_tag = '0;
    frm = '0; flush = 1'b0; rsp_ready = 1'b0; tb_done = 1'b0;
    stub_lat = 4; stub_res = '0; stub_nv = 1'b0; stub_nx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_outputs", 64'({sq_start, rsp_valid, rsp_illegal, rsp_fflags, rsp_cycles, rsp_tag, sq_rm}), 64'(0));
    chk("rst_data", 64'({sq_operand, rsp_result}), 64'(0));
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i, 0);

    run_vec(vecs[0], 7, 10);

    flush_drain(5);
    run_vec(vecs[1], 8, 0);
    flush_drain(0);
    run_vec(vecs[2], 9, 0);

    // flush in the same cycle as sq_done: straight back to IDLE
    stub_lat = 8;
    req_valid = 1'b1; req_operand = 32'h40800000; req_rm = 3'b000; req_tag = 5'd4;
    s0 = n_start;
    step();
    req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (sq_done) begin got = 1; break; end
      step();
    end
    chk("cd_done_wait", 64'(got), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("cd_no_rsp", 64'(rsp_valid), 64'(0));
    chk("cd_ready", 64'(req_ready), 64'(1));
    step();
    chk("cd_no_rsp_late", 64'(rsp_valid), 64'(0));
    chk("cd_start_count", 64'(n_start - s0), 64'(1));

    // flush on the acceptance cycle drops the request
    s0 = n_start;
    req_valid = 1'b1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("fa_no_start", 64'(sq_start), 64'(0));
    chk("fa_no_rsp", 64'(rsp_valid), 64'(0));
    chk("fa_ready", 64'(req_ready), 64'(1));
    step();
    chk("fa_start_count", 64'(n_start - s0), 64'(0));

    // spurious done in IDLE blocks acceptance for that cycle only
    tb_done = 1'b1;
    #1;
    chk("sp_ready_low", 64'(req_ready), 64'(0));
    step();
    tb_done = 1'b0;
    #1;
    chk("sp_no_rsp", 64'(rsp_valid), 64'(0));
    chk("sp_ready", 64'(req_ready), 64'(1));

    run_vec(vecs[5], 10, 0);

    chk("operand_rm_stable", 64'(stab_bad), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
    $finish;
  end

endmodule
